// File: rtl/oamdma_pkg.sv
// Shared definitions for the sprite DMA engine: bus register addresses used
// by the CPU-side decode, the FSM state type, and a small state decode helper.
package oamdma_pkg;

  // CPU register addresses involved in sprite DMA.
  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  // DMA engine states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALTREQ = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_READ    = 3'd3,
    ST_WRITE   = 3'd4
  } state_e;

  // True in every state where the CPU has to be held off the bus.
  function automatic logic state_halts(input state_e s);
    logic r;
    case (s)
      ST_HALTREQ, ST_ALIGN, ST_READ, ST_WRITE: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/oamdma.sv
// Sprite DMA engine. A CPU write to $4014 latches a page number; the engine
// then stalls the CPU and copies that 256-byte page into OAM with one bus
// read (even CPU cycle) followed by one $2004 write (odd CPU cycle) per byte.
// All state advances only on tick; reset abandons a transfer immediately.
module oamdma
  import oamdma_pkg::*;
#(
  parameter int NBYTES = 256  // bytes per transfer, at most 256 (8-bit counter)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr4014,
  input  logic [7:0]  regwdata,
  input  logic        cpuwr,
  input  logic [7:0]  memrdata,
  output logic        halt,
  output logic [15:0] dmaaddr,
  output logic        dmard,
  output logic        dmawr,
  output logic [7:0]  dmawdata,
  output logic        busy
);

  // Terminal count; the write of this byte is the last one of the transfer.
  localparam logic [7:0] LAST_CNT = 8'(NBYTES - 1);

  state_e     state_q, state_d;
  logic       odd_q,   odd_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] data_q,  data_d;

  // Next-state logic: FSM transitions, parity toggle, page/count/data capture.
  always_comb begin
    state_d = state_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    data_d  = data_q;
    if (tick) begin
      odd_d = ~odd_q;
      case (state_q)
        ST_IDLE: begin
          if (wr4014) begin
            state_d = ST_HALTREQ;
            page_d  = regwdata;
            cnt_d   = 8'h00;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HALTREQ: begin
          // A CPU write cycle cannot be stalled; wait for its next read cycle.
          if (cpuwr) begin
            state_d = ST_HALTREQ;
          end else if (odd_q) begin
            state_d = ST_READ;   // next cycle is already a get cycle
          end else begin
            state_d = ST_ALIGN;  // burn one cycle to land reads on even cycles
          end
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          state_d = ST_WRITE;
          data_d  = memrdata;
        end
        ST_WRITE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
      odd_d   = odd_q;
    end
  end

  // State registers with asynchronous reset that abandons any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      odd_q   <= 1'b0;
      cnt_q   <= 8'h00;
      page_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      data_q  <= data_d;
    end
  end

  // Output decode from registered state only, so reset clears them at once.
  always_comb begin
    halt     = state_halts(state_q);
    busy     = state_halts(state_q);
    dmawdata = data_q;
    if (state_q == ST_READ) begin
      dmard   = 1'b1;
      dmaaddr = {page_q, cnt_q};
    end else begin
      dmard   = 1'b0;
      dmaaddr = 16'h0000;
    end
    if (state_q == ST_WRITE) begin
      dmawr = 1'b1;
    end else begin
      dmawr = 1'b0;
    end
  end

endmodule
